// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NUM_RD async read ports, NUM_WR sync write ports, busy scoreboard.
// Reads 0-cycle (optional same-cycle write bypass), writes/reserves take effect at the next rising edge.
module reg_file_mp #(
    parameter int reg_addr_width = 5,
    parameter int reg_data_width = 32,
    parameter int reg_depth      = 32,
    parameter int NUM_RD         = 2,
    parameter int NUM_WR         = 1,
    parameter int ZERO_REG       = 1,
    parameter int BYPASS         = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_WR-1:0]                  wr_en,
    input  logic [NUM_WR*reg_addr_width-1:0]   wr_addr,
    input  logic [NUM_WR*reg_data_width-1:0]   wr_data,
    input  logic [NUM_RD*reg_addr_width-1:0]   r_addr,
    output logic [NUM_RD*reg_data_width-1:0]   r_data,
    input  logic                               rsv_en,
    input  logic [reg_addr_width-1:0]          rsv_addr,
    output logic [NUM_RD-1:0]                  r_busy
);
    localparam int AW = reg_addr_width;
    localparam int DW = reg_data_width;

    logic [reg_depth-1:0][DW-1:0] mem_q, mem_d;
    logic [reg_depth-1:0]         busy_q, busy_d;

    // An address is "live" when it maps to a real, writable register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < reg_depth) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        // Ascending port order lets the highest-numbered port win a conflict.
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && addr_ok(wr_addr[p*AW +: AW])) begin
                mem_d[wr_addr[p*AW +: AW]]  = wr_data[p*DW +: DW];
                busy_d[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        // A new producer supersedes one retiring in the same cycle.
        if (rsv_en && addr_ok(rsv_addr)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        r_data = '0;
        r_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (addr_ok(r_addr[i*AW +: AW])) begin
                r_data[i*DW +: DW] = mem_q[r_addr[i*AW +: AW]];
                r_busy[i]          = busy_q[r_addr[i*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NUM_WR; p++) begin
                        if (wr_en[p] && (wr_addr[p*AW +: AW] == r_addr[i*AW +: AW])) begin
                            r_data[i*DW +: DW] = wr_data[p*DW +: DW];
                            r_busy[i]          = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule
